// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller port bundle: decoded pipeline fields in, stall/bubble controls out.
// Pure wiring, no latency of its own.
// The pipeline side (master) drives the fields; the controller (slave) drives the controls.
interface pipeline_hazard_ctrl_if #(
   parameter int CNT_W = 16
);
   // Hazard sources observed in ID / EX / MEM
   logic [4:0]       id_rs;
   logic [4:0]       id_rt;
   logic             id_use_rs;
   logic             id_use_rt;
   logic             id_hilo;
   logic             ex_lw;
   logic             ex_RegWr;
   logic [4:0]       ex_rw;
   logic             ex_mult;
   logic             mem_taken;
   logic             mem_exc;

   // Controls returned to the stage registers and PC mux
   logic             pc_stall;
   logic             ifid_stall;
   logic             ifid_bubble;
   logic             idex_bubble;
   logic             exmem_bubble;
   logic             exc_redirect;
   logic             mult_busy;
   logic [CNT_W-1:0] stall_cycles;

   modport master (
      output id_rs, id_rt, id_use_rs, id_use_rt, id_hilo,
             ex_lw, ex_RegWr, ex_rw, ex_mult, mem_taken, mem_exc,
      input  pc_stall, ifid_stall, ifid_bubble, idex_bubble, exmem_bubble,
             exc_redirect, mult_busy, stall_cycles
   );

   modport slave (
      input  id_rs, id_rt, id_use_rs, id_use_rt, id_hilo,
             ex_lw, ex_RegWr, ex_rw, ex_mult, mem_taken, mem_exc,
      output pc_stall, ifid_stall, ifid_bubble, idex_bubble, exmem_bubble,
             exc_redirect, mult_busy, stall_cycles
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline (load-use, HI/LO busy, MEM flush/redirect).
// Controls are combinational from inputs and registered state; they are sampled at the same posedge.
// Flush beats stall; a stall holds PC and IF/ID and injects a bubble into ID/EX.
module pipeline_hazard_ctrl #(
   parameter int MULT_LAT = 4,   // EX occupancy of mult in cycles; 1 means never busy
   parameter int CNT_W    = 16   // must match the CNT_W of the connected interface
) (
   input logic                    clk,
   input logic                    rst,
   pipeline_hazard_ctrl_if.slave  hz
);

   localparam int CW = $clog2(MULT_LAT + 1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(MULT_LAT - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam bit MULT_MULTI = (MULT_LAT > 1);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } mult_state_t;

   mult_state_t      state;
   logic [CW-1:0]    mult_cnt;
   logic [CNT_W-1:0] stall_cnt;

   logic flush;
   logic load_use;
   logic rs_hit;
   logic rt_hit;
   logic busy;
   logic hilo_stall;
   logic stall;
   logic mult_start;

   // Hazard detection: the terms every control output is built from
   always_comb begin
      flush      = hz.mem_taken | hz.mem_exc;
      rs_hit     = hz.id_use_rs & (hz.id_rs == hz.ex_rw);
      rt_hit     = hz.id_use_rt & (hz.id_rt == hz.ex_rw);
      load_use   = hz.ex_lw & hz.ex_RegWr & (hz.ex_rw != 5'd0) & (rs_hit | rt_hit);
      // Reset masks the busy view so nothing stalls while the pipe is being cleared
      busy       = (state == BUSY) & ~rst;
      hilo_stall = busy & hz.id_hilo;
      stall      = ~rst & ~flush & (load_use | hilo_stall);
      // A mult caught in EX by a flush is younger than the flushing instruction, so it never starts
      mult_start = MULT_MULTI & hz.ex_mult & ~flush;
   end

   // Control outputs: reset clears every stage, then flush, then stall, else free-running
   always_comb begin
      hz.pc_stall     = 1'b0;
      hz.ifid_stall   = 1'b0;
      hz.ifid_bubble  = 1'b0;
      hz.idex_bubble  = 1'b0;
      hz.exmem_bubble = 1'b0;
      hz.exc_redirect = 1'b0;
      if (rst) begin
         hz.ifid_bubble  = 1'b1;
         hz.idex_bubble  = 1'b1;
         hz.exmem_bubble = 1'b1;
      end else if (flush) begin
         hz.ifid_bubble  = 1'b1;
         hz.idex_bubble  = 1'b1;
         hz.exmem_bubble = 1'b1;
         hz.exc_redirect = hz.mem_exc;
      end else if (stall) begin
         // Bubble in ID/EX removes the load (or keeps the HI/LO user out of EX),
         // so a load-use stall resolves itself after one cycle
         hz.pc_stall    = 1'b1;
         hz.ifid_stall  = 1'b1;
         hz.idex_bubble = 1'b1;
      end
      hz.mult_busy    = busy;
      hz.stall_cycles = stall_cnt;
   end

   // Multiplier occupancy FSM; an in-flight mult is older than any flush and keeps counting
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         mult_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (mult_start) begin
                  state    <= BUSY;
                  mult_cnt <= CNT_LOAD;
               end
            end
            BUSY: begin
               // ex_mult here is impossible in a correct pipe and is ignored
               if (mult_cnt <= CNT_ONE) begin
                  state    <= IDLE;
                  mult_cnt <= '0;
               end else begin
                  mult_cnt <= mult_cnt - CNT_ONE;
               end
            end
            default: begin
               state    <= IDLE;
               mult_cnt <= '0;
            end
         endcase
      end
   end

   // Saturating count of stall cycles; flush cycles never reach here because stall is masked
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
         stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (MULT_LAT=4, CNT_W=4).
// Inputs change just after the falling edge and outputs are checked 1 ns later,
// so each step's inputs are sampled by the following rising edge.
module tb_pipeline_hazard_ctrl;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   pipeline_hazard_ctrl_if #(.CNT_W(4)) hz ();

   pipeline_hazard_ctrl #(.MULT_LAT(4), .CNT_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .hz  (hz)
   );

   always #5 clk = ~clk;

   // Control vector order: {pc_stall, ifid_stall, ifid_bubble, idex_bubble, exmem_bubble, exc_redirect}
   localparam logic [5:0] C_NONE  = 6'b000000;
   localparam logic [5:0] C_STALL = 6'b110100;
   localparam logic [5:0] C_FLUSH = 6'b001110;
   localparam logic [5:0] C_EXC   = 6'b001111;

   task automatic chk_ctrl(input string tag, input logic [5:0] exp);
      logic [5:0] obs;
      obs = {hz.pc_stall, hz.ifid_stall, hz.ifid_bubble, hz.idex_bubble,
             hz.exmem_bubble, hz.exc_redirect};
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: ctrl observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic clr();
      hz.id_rs     = 5'd0;
      hz.id_rt     = 5'd0;
      hz.id_use_rs = 1'b0;
      hz.id_use_rt = 1'b0;
      hz.id_hilo   = 1'b0;
      hz.ex_lw     = 1'b0;
      hz.ex_RegWr  = 1'b0;
      hz.ex_rw     = 5'd0;
      hz.ex_mult   = 1'b0;
      hz.mem_taken = 1'b0;
      hz.mem_exc   = 1'b0;
   endtask

   // Next step: inputs applied after the falling edge
   task automatic step();
      @(negedge clk);
      clr();
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      rst = 1'b1;
      clr();

      // ---- reset state ----
      @(negedge clk); settle();
      chk_ctrl("rst_ctrl", C_FLUSH);
      chk_val("rst_busy", 32'(hz.mult_busy), 0);
      step(); settle();
      chk_val("rst_cnt", 32'(hz.stall_cycles), 0);

      // ---- 1. load-use on rs ----
      step(); rst = 1'b0; settle();
      chk_ctrl("idle_ctrl", C_NONE);
      step();
      hz.ex_lw = 1'b1; hz.ex_RegWr = 1'b1; hz.ex_rw = 5'd8;
      hz.id_rs = 5'd8; hz.id_use_rs = 1'b1; settle();
      chk_ctrl("lu_rs_stall", C_STALL);
      step(); settle();
      chk_ctrl("lu_released", C_NONE);
      chk_val("lu_cnt1", 32'(hz.stall_cycles), 1);
      // r0 destination never hazards
      step();
      hz.ex_lw = 1'b1; hz.ex_RegWr = 1'b1; hz.ex_rw = 5'd0;
      hz.id_rs = 5'd0; hz.id_use_rs = 1'b1; settle();
      chk_ctrl("lu_r0_none", C_NONE);
      // rt match only counts when rt is actually read
      step();
      hz.ex_lw = 1'b1; hz.ex_RegWr = 1'b1; hz.ex_rw = 5'd5;
      hz.id_rt = 5'd5; hz.id_use_rt = 1'b0; settle();
      chk_ctrl("lu_rt_unused", C_NONE);
      hz.id_use_rt = 1'b1; settle();
      chk_ctrl("lu_rt_stall", C_STALL);
      step(); settle();
      chk_val("lu_cnt2", 32'(hz.stall_cycles), 2);

      // ---- 2. mult busy + HI/LO stall ----
      step(); hz.ex_mult = 1'b1; settle();
      chk_val("mult_start_busy", 32'(hz.mult_busy), 0);
      chk_ctrl("mult_start_ctrl", C_NONE);
      for (int i = 0; i < 3; i++) begin
         step(); hz.id_hilo = 1'b1; settle();
         chk_val("hilo_busy", 32'(hz.mult_busy), 1);
         chk_ctrl("hilo_stall", C_STALL);
      end
      step(); hz.id_hilo = 1'b1; settle();
      chk_val("hilo_done_busy", 32'(hz.mult_busy), 0);
      chk_ctrl("hilo_release", C_NONE);
      chk_val("hilo_cnt", 32'(hz.stall_cycles), 5);

      // ---- 3. branch flush beats load-use ----
      step();
      hz.ex_lw = 1'b1; hz.ex_RegWr = 1'b1; hz.ex_rw = 5'd9;
      hz.id_rs = 5'd9; hz.id_use_rs = 1'b1; hz.mem_taken = 1'b1; settle();
      chk_ctrl("taken_vs_lu", C_FLUSH);
      step(); settle();
      chk_val("taken_cnt", 32'(hz.stall_cycles), 5);

      // ---- 4. exception discards a same-cycle mult ----
      step(); hz.mem_exc = 1'b1; hz.ex_mult = 1'b1; settle();
      chk_ctrl("exc_redirect", C_EXC);
      step(); settle();
      chk_val("exc_no_mult", 32'(hz.mult_busy), 0);
      // earlier mult survives a later branch flush
      step(); hz.ex_mult = 1'b1;
      step(); hz.mem_taken = 1'b1; hz.id_hilo = 1'b1; settle();
      chk_val("flush_busy1", 32'(hz.mult_busy), 1);
      chk_ctrl("flush_over_hilo", C_FLUSH);
      step(); settle();
      chk_val("flush_busy2", 32'(hz.mult_busy), 1);
      step(); settle();
      chk_val("flush_busy3", 32'(hz.mult_busy), 1);
      step(); settle();
      chk_val("flush_busy_end", 32'(hz.mult_busy), 0);
      chk_val("flush_cnt", 32'(hz.stall_cycles), 5);

      // ---- 5. reset mid-mult ----
      step(); hz.ex_mult = 1'b1;
      step(); settle();
      chk_val("pre_rst_busy", 32'(hz.mult_busy), 1);
      step(); rst = 1'b1; hz.id_hilo = 1'b1;
      hz.ex_lw = 1'b1; hz.ex_RegWr = 1'b1; hz.ex_rw = 5'd3;
      hz.id_rs = 5'd3; hz.id_use_rs = 1'b1; settle();
      chk_ctrl("rst_mid_ctrl", C_FLUSH);
      chk_val("rst_mid_busy", 32'(hz.mult_busy), 0);
      step(); rst = 1'b0; hz.id_hilo = 1'b1; settle();
      chk_val("post_rst_busy", 32'(hz.mult_busy), 0);
      chk_val("post_rst_cnt", 32'(hz.stall_cycles), 0);
      chk_ctrl("post_rst_ctrl", C_NONE);

      // ---- 6. counter saturation over 21 HI/LO stalls ----
      for (int r = 0; r < 7; r++) begin
         step(); hz.ex_mult = 1'b1;
         for (int i = 0; i < 3; i++) begin
            step(); hz.id_hilo = 1'b1;
         end
         if (r == 3) begin
            step(); settle();
            chk_val("sat_cnt12", 32'(hz.stall_cycles), 12);
         end
      end
      step(); settle();
      chk_val("sat_cnt15", 32'(hz.stall_cycles), 15);
      chk_ctrl("sat_idle", C_NONE);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
